// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the coherent bus controller and its arbiter.
//   word_t      : one data/address word
//   ramstate_t  : handshake state reported by the single-port RAM
//   busstate_t  : bus controller transaction state
//   idxWidth()  : width of an index into n requesters (never zero)
// ---------------------------------------------------------------------------
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SNOOP   = 3'd1,
      UPGRADE = 3'd2,
      C2C     = 3'd3,
      RAM_RD  = 3'd4,
      WB      = 3'd5,
      IFETCH  = 3'd6
   } busstate_t;

   // A single requester still needs a one-bit index so ports never collapse.
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin search over N request lines starting at a caller-owned pointer.
// The caller advances the pointer; this block is purely combinational.
//   req   in  N   request lines
//   ptr   in  IW  index where the search starts
//   grant out IW  index of the first active request at or after ptr
//   valid out 1   at least one request is active
// ---------------------------------------------------------------------------
module rr_arbiter
   import cpu_types_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idxWidth(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] grant,
   output logic          valid
);

   // Walk the requesters in ring order from ptr; the first active one wins,
   // later hits are ignored once valid is set.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         int idx;
         idx = (int'(ptr) + i) % N;
         if (!valid && req[idx]) begin
            grant = IW'(idx);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/coherent_bus_ctrl.sv
// ---------------------------------------------------------------------------
// coherent_bus_ctrl
// MSI coherence bus controller between CPUS icache/dcache pairs and one RAM.
// Arbitrates data and instruction traffic round-robin, broadcasts snoops,
// and serves misses cache-to-cache (with simultaneous RAM writeback) or
// from RAM.
//   CLK, RST                     clock, synchronous active-high reset
//   iREN/iaddr -> iwait/iload    instruction fetch per CPU
//   dREN/dWEN/daddr/dstore       data read / writeback per CPU
//   dwait/dload                  data completion strobe (active low) / data
//   ccwrite/cctrans              requester wants M / line changing state
//   ccwait/ccinv/ccsnoopaddr     snoop stall / invalidate / address
//   ramload/ramstate             RAM read data / handshake
//   ramREN/ramWEN/ramaddr/ramstore  RAM strobes, address, write data
// ---------------------------------------------------------------------------
module coherent_bus_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CPUS        = 2,
   parameter int BLOCK_WORDS = 2,
   parameter int WORD_W      = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [CPUS-1:0]        iREN,
   input  logic [CPUS*WORD_W-1:0] iaddr,
   output logic [CPUS-1:0]        iwait,
   output logic [CPUS*WORD_W-1:0] iload,
   input  logic [CPUS-1:0]        dREN,
   input  logic [CPUS-1:0]        dWEN,
   input  logic [CPUS*WORD_W-1:0] daddr,
   input  logic [CPUS*WORD_W-1:0] dstore,
   output logic [CPUS-1:0]        dwait,
   output logic [CPUS*WORD_W-1:0] dload,
   input  logic [CPUS-1:0]        ccwrite,
   input  logic [CPUS-1:0]        cctrans,
   output logic [CPUS-1:0]        ccwait,
   output logic [CPUS-1:0]        ccinv,
   output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
   input  logic [WORD_W-1:0]      ramload,
   input  ramstate_t              ramstate,
   output logic                   ramREN,
   output logic                   ramWEN,
   output logic [WORD_W-1:0]      ramaddr,
   output logic [WORD_W-1:0]      ramstore
);

   localparam int IW = idxWidth(CPUS);
   localparam int CW = idxWidth(BLOCK_WORDS);
   localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);
   localparam logic [IW-1:0] LAST_CPU  = IW'(CPUS - 1);

   busstate_t       r_state, w_nextState;
   logic [IW-1:0]   r_req, w_nextReq;
   logic [IW-1:0]   r_snp, w_nextSnp;
   logic [IW-1:0]   r_dptr, w_nextDptr;
   logic [IW-1:0]   r_iptr, w_nextIptr;
   logic [CW-1:0]   r_cnt, w_nextCnt;

   logic [CPUS-1:0] w_wbReq, w_dReq;
   logic [IW-1:0]   w_dGrant, w_iGrant, w_snpIdx;
   logic            w_dValid, w_iValid, w_snpFound;
   logic            w_ack, w_wordDone, w_abort;

   function automatic logic [IW-1:0] incIdx(input logic [IW-1:0] x);
      return (x == LAST_CPU) ? '0 : x + 1'b1;
   endfunction

   // Only one data search exists, so the request vector it sees is the
   // highest-priority class that has any member: clean writebacks first,
   // then coherence transactions, then plain reads.
   assign w_wbReq = dWEN & ~cctrans;
   assign w_dReq  = (|w_wbReq) ? w_wbReq : ((|cctrans) ? cctrans : dREN);
   assign w_ack   = (ramstate == ACCESS);

   rr_arbiter #(.N(CPUS), .IW(IW)) u_dArb (
      .req   (w_dReq),
      .ptr   (r_dptr),
      .grant (w_dGrant),
      .valid (w_dValid)
   );

   rr_arbiter #(.N(CPUS), .IW(IW)) u_iArb (
      .req   (iREN),
      .ptr   (r_iptr),
      .grant (w_iGrant),
      .valid (w_iValid)
   );

   // Find the cache holding the line in M: the first other CPU, counting
   // upward from the requester, that answers the snoop with a writeback.
   always_comb begin
      w_snpFound = 1'b0;
      w_snpIdx   = '0;
      for (int i = 1; i < CPUS; i++) begin
         int j;
         j = (int'(r_req) + i) % CPUS;
         if (!w_snpFound && dWEN[j]) begin
            w_snpFound = 1'b1;
            w_snpIdx   = IW'(j);
         end
      end
   end

   // All registered bus state. Reset drops any transfer in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_req   <= '0;
         r_snp   <= '0;
         r_dptr  <= '0;
         r_iptr  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         r_req   <= w_nextReq;
         r_snp   <= w_nextSnp;
         r_dptr  <= w_nextDptr;
         r_iptr  <= w_nextIptr;
         r_cnt   <= w_nextCnt;
      end
   end

   // Next state and every output. Outputs depend on the registered state and
   // indices; while RST is high they sit at their idle values so an aborted
   // transfer stops acknowledging and strobing in the reset cycle itself.
   // Each data state reports either a finished word or a withdrawn request,
   // and the shared block-end / abort bookkeeping follows the case.
   always_comb begin
      w_nextState = r_state;
      w_nextReq   = r_req;
      w_nextSnp   = r_snp;
      w_nextDptr  = r_dptr;
      w_nextIptr  = r_iptr;
      w_nextCnt   = r_cnt;
      w_wordDone  = 1'b0;
      w_abort     = 1'b0;
      iwait       = '1;
      dwait       = '1;
      iload       = '0;
      dload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;

      if (!RST) begin
         case (r_state)
            IDLE: begin
               w_nextCnt = '0;
               if (w_dValid) begin
                  w_nextReq = w_dGrant;
                  if (|w_wbReq)       w_nextState = WB;
                  else if (|cctrans)  w_nextState = SNOOP;
                  else                w_nextState = RAM_RD;
               end else if (w_iValid) begin
                  w_nextReq   = w_iGrant;
                  w_nextState = IFETCH;
               end
            end

            SNOOP, UPGRADE: begin
               for (int j = 0; j < CPUS; j++) begin
                  if (IW'(j) != r_req) begin
                     ccwait[j] = 1'b1;
                     ccinv[j]  = ccwrite[r_req];
                     ccsnoopaddr[j*WORD_W +: WORD_W] = daddr[int'(r_req)*WORD_W +: WORD_W];
                  end
               end
               if (r_state == UPGRADE) begin
                  dwait[r_req] = 1'b0;
                  w_nextState  = IDLE;
                  w_nextDptr   = incIdx(r_req);
               end else if (w_snpFound) begin
                  w_nextSnp   = w_snpIdx;
                  w_nextState = C2C;
               end else if (!dREN[r_req]) begin
                  w_nextState = UPGRADE;
               end else begin
                  w_nextState = RAM_RD;
               end
            end

            C2C: begin
               ramWEN   = 1'b1;
               ramaddr  = daddr[int'(r_snp)*WORD_W +: WORD_W];
               ramstore = dstore[int'(r_snp)*WORD_W +: WORD_W];
               dload[int'(r_req)*WORD_W +: WORD_W] = dstore[int'(r_snp)*WORD_W +: WORD_W];
               ccwait[r_snp] = 1'b1;
               ccinv[r_snp]  = ccwrite[r_req];
               ccsnoopaddr[int'(r_snp)*WORD_W +: WORD_W] = daddr[int'(r_req)*WORD_W +: WORD_W];
               if (!dREN[r_req] || !dWEN[r_snp]) begin
                  w_abort = 1'b1;
               end else if (w_ack) begin
                  dwait[r_req] = 1'b0;
                  dwait[r_snp] = 1'b0;
                  w_wordDone   = 1'b1;
               end
            end

            RAM_RD: begin
               ramREN  = 1'b1;
               ramaddr = daddr[int'(r_req)*WORD_W +: WORD_W];
               dload[int'(r_req)*WORD_W +: WORD_W] = ramload;
               if (!dREN[r_req]) begin
                  w_abort = 1'b1;
               end else if (w_ack) begin
                  dwait[r_req] = 1'b0;
                  w_wordDone   = 1'b1;
               end
            end

            WB: begin
               ramWEN   = 1'b1;
               ramaddr  = daddr[int'(r_req)*WORD_W +: WORD_W];
               ramstore = dstore[int'(r_req)*WORD_W +: WORD_W];
               if (!dWEN[r_req]) begin
                  w_abort = 1'b1;
               end else if (w_ack) begin
                  dwait[r_req] = 1'b0;
                  w_wordDone   = 1'b1;
               end
            end

            IFETCH: begin
               ramREN  = 1'b1;
               ramaddr = iaddr[int'(r_req)*WORD_W +: WORD_W];
               iload[int'(r_req)*WORD_W +: WORD_W] = ramload;
               if (!iREN[r_req] || w_ack) begin
                  iwait[r_req] = !(iREN[r_req] && w_ack);
                  w_nextState  = IDLE;
                  w_nextIptr   = incIdx(r_req);
               end
            end

            default: w_nextState = IDLE;
         endcase

         if (w_abort) begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
            w_nextDptr  = incIdx(r_req);
         end else if (w_wordDone) begin
            if (r_cnt == LAST_WORD) begin
               w_nextCnt   = '0;
               w_nextState = IDLE;
               w_nextDptr  = incIdx(r_req);
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_coherent_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_coherent_bus_ctrl
// Directed bench for a two-CPU, two-word-block bus controller. Stimulus
// pushes the acknowledgements it expects into a queue; a monitor pops and
// compares one entry for every dwait/iwait pulse the DUT produces. RAM reads
// return {16'hBEEF, addr[15:0]} after a two-cycle access.
// ---------------------------------------------------------------------------
module tb_coherent_bus_ctrl;
   import cpu_types_pkg::*;

   localparam int CPUS = 2;
   localparam int BW   = 2;
   localparam int WW   = 32;
   localparam int LAT  = 2;

   logic            CLK;
   logic            RST;
   logic [CPUS-1:0] iREN, iwait, dREN, dWEN, dwait, ccwrite, cctrans, ccwait, ccinv;
   logic [CPUS*WW-1:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
   logic [WW-1:0]   ramload, ramaddr, ramstore;
   ramstate_t       ramstate = FREE;
   logic            ramREN, ramWEN;

   typedef struct {
      int          kind;
      int          cpu;
      logic [31:0] data;
      logic [31:0] addr;
      logic [31:0] store;
      logic        wen;
      logic        ren;
   } exp_t;

   exp_t expQ[$];
   int   checks   = 0;
   int   failures = 0;
   int   ramCnt   = 0;

   coherent_bus_ctrl #(.CPUS(CPUS), .BLOCK_WORDS(BW), .WORD_W(WW)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
      .ccsnoopaddr(ccsnoopaddr),
      .ramload(ramload), .ramstate(ramstate),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   assign ramload = {16'hBEEF, ramaddr[15:0]};

   // RAM model: every strobed word sees BUSY then ACCESS.
   always @(posedge CLK) begin
      #2;
      if (ramREN || ramWEN) begin
         if (ramCnt == LAT - 1) begin
            ramstate = ACCESS;
            ramCnt   = 0;
         end else begin
            ramstate = BUSY;
            ramCnt   = ramCnt + 1;
         end
      end else begin
         ramstate = FREE;
         ramCnt   = 0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   task automatic pushExp(input int kind, input int cpu, input logic [31:0] data,
                          input logic [31:0] addr, input logic [31:0] store,
                          input logic wen, input logic ren);
      exp_t e;
      e.kind = kind; e.cpu = cpu; e.data = data; e.addr = addr;
      e.store = store; e.wen = wen; e.ren = ren;
      expQ.push_back(e);
   endtask

   task automatic checkAck(input int kind, input int cpu, input logic [31:0] data);
      exp_t e;
      checks++;
      if (expQ.size() == 0) begin
         failures++;
         $display("[TB] FAIL unexpected_ack: got kind=%0d cpu=%0d data=0x%08h expected no ack",
                  kind, cpu, data);
         return;
      end
      e = expQ.pop_front();
      if (e.kind != kind || e.cpu != cpu || e.data !== data || e.addr !== ramaddr ||
          e.store !== ramstore || e.wen !== ramWEN || e.ren !== ramREN) begin
         failures++;
         $display("[TB] FAIL ack: got kind=%0d cpu=%0d data=0x%08h addr=0x%08h store=0x%08h wen=%b ren=%b expected kind=%0d cpu=%0d data=0x%08h addr=0x%08h store=0x%08h wen=%b ren=%b",
                  kind, cpu, data, ramaddr, ramstore, ramWEN, ramREN,
                  e.kind, e.cpu, e.data, e.addr, e.store, e.wen, e.ren);
      end
   endtask

   // Monitor: every low wait strobe is an acknowledgement to be matched
   // against the scoreboard; data acks are checked before instruction acks.
   always @(negedge CLK) begin
      if (!RST) begin
         for (int c = 0; c < CPUS; c++)
            if (!dwait[c]) checkAck(1, c, dload[c*WW +: WW]);
         for (int c = 0; c < CPUS; c++)
            if (!iwait[c]) checkAck(0, c, iload[c*WW +: WW]);
         if (ramREN || ramWEN)
            checkOutput("strobe_exclusive", 32'(ramREN & ramWEN), 32'd0);
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // code 0: iwait[cpu] low, 1: dwait[cpu] low, 2: ccwait[cpu] high, 3: ramREN high.
   // Returns at the negedge where the event is seen.
   task automatic waitFor(input int code, input int cpu, input string name);
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge CLK);
         case (code)
            0:       hit = !iwait[cpu];
            1:       hit = !dwait[cpu];
            2:       hit = ccwait[cpu];
            default: hit = ramREN;
         endcase
         if (hit) break;
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("[TB] FAIL timeout_%s: got no event expected event within 40 cycles", name);
      end
   endtask

   task automatic applyStimulus(input int cpu, input logic ren, input logic wen,
                                input logic trans, input logic wr,
                                input logic [31:0] addr, input logic [31:0] store);
      dREN[cpu]    = ren;
      dWEN[cpu]    = wen;
      cctrans[cpu] = trans;
      ccwrite[cpu] = wr;
      daddr[cpu*WW +: WW]  = addr;
      dstore[cpu*WW +: WW] = store;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      RST = 1'b1;
      iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
      ccwrite = '0; cctrans = '0;
      step(); step();

      // Reset state
      @(negedge CLK);
      checkOutput("rst_iwait",  32'(iwait),  32'h3);
      checkOutput("rst_dwait",  32'(dwait),  32'h3);
      checkOutput("rst_ccwait", 32'(ccwait), 32'h0);
      checkOutput("rst_ccinv",  32'(ccinv),  32'h0);
      checkOutput("rst_strobes", 32'({ramREN, ramWEN}), 32'h0);
      checkOutput("rst_ramaddr", ramaddr, 32'h0);
      checkOutput("rst_loads", 32'({|iload, |dload, |ccsnoopaddr, |ramstore}), 32'h0);
      checkOutput("rst_state", 32'(dut.r_state), 32'(IDLE));
      checkOutput("rst_ptrs",  32'({dut.r_dptr, dut.r_iptr, dut.r_cnt}), 32'h0);
      step();
      RST = 1'b0;
      step();

      // Two competing instruction fetches, served 0 then 1
      iaddr[0*WW +: WW] = 32'h40;
      iaddr[1*WW +: WW] = 32'h80;
      pushExp(0, 0, 32'hBEEF0040, 32'h40, 32'h0, 1'b0, 1'b1);
      pushExp(0, 1, 32'hBEEF0080, 32'h80, 32'h0, 1'b0, 1'b1);
      iREN = 2'b11;
      waitFor(0, 0, "ifetch0"); step(); iREN[0] = 1'b0;
      checkOutput("iptr_after_0", 32'(dut.r_iptr), 32'd1);
      waitFor(0, 1, "ifetch1"); step(); iREN[1] = 1'b0;
      checkOutput("iptr_after_1", 32'(dut.r_iptr), 32'd0);

      // Read miss with snoop, no M copy: served from RAM
      applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
      pushExp(1, 0, 32'hBEEF0100, 32'h100, 32'h0, 1'b0, 1'b1);
      pushExp(1, 0, 32'hBEEF0104, 32'h104, 32'h0, 1'b0, 1'b1);
      waitFor(2, 1, "snoop_rd");
      checkOutput("snoop_addr1", ccsnoopaddr[1*WW +: WW], 32'h100);
      checkOutput("snoop_inv1",  32'(ccinv[1]),  32'd0);
      checkOutput("snoop_wait0", 32'(ccwait[0]), 32'd0);
      waitFor(1, 0, "rd_w0"); step(); daddr[0*WW +: WW] = 32'h104;
      waitFor(1, 0, "rd_w1"); step(); applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("dptr_after_rd", 32'(dut.r_dptr), 32'd1);

      // Read miss answered by CPU1's M copy: cache-to-cache plus writeback
      applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
      daddr[1*WW +: WW]  = 32'h200;
      dstore[1*WW +: WW] = 32'hDEADBEEF;
      pushExp(1, 0, 32'hDEADBEEF, 32'h200, 32'hDEADBEEF, 1'b1, 1'b0);
      pushExp(1, 1, 32'h0,        32'h200, 32'hDEADBEEF, 1'b1, 1'b0);
      pushExp(1, 0, 32'hCAFEF00D, 32'h204, 32'hCAFEF00D, 1'b1, 1'b0);
      pushExp(1, 1, 32'h0,        32'h204, 32'hCAFEF00D, 1'b1, 1'b0);
      waitFor(2, 1, "snoop_c2c");
      dWEN[1] = 1'b1;
      waitFor(1, 0, "c2c_w0"); step();
      daddr[0*WW +: WW]  = 32'h204;
      daddr[1*WW +: WW]  = 32'h204;
      dstore[1*WW +: WW] = 32'hCAFEF00D;
      waitFor(1, 1, "c2c_w1"); step();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("dptr_after_c2c", 32'(dut.r_dptr), 32'd1);

      // Two writebacks with dptr=1 and a fetch waiting behind them
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h11110000);
      applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h22220000);
      iaddr[0*WW +: WW] = 32'h40;
      iREN[0] = 1'b1;
      pushExp(1, 1, 32'h0, 32'h500, 32'h22220000, 1'b1, 1'b0);
      pushExp(1, 1, 32'h0, 32'h504, 32'h22220001, 1'b1, 1'b0);
      pushExp(1, 0, 32'h0, 32'h400, 32'h11110000, 1'b1, 1'b0);
      pushExp(1, 0, 32'h0, 32'h404, 32'h11110001, 1'b1, 1'b0);
      pushExp(0, 0, 32'hBEEF0040, 32'h40, 32'h0, 1'b0, 1'b1);
      waitFor(1, 1, "wb1_w0"); step();
      daddr[1*WW +: WW] = 32'h504; dstore[1*WW +: WW] = 32'h22220001;
      waitFor(1, 1, "wb1_w1"); step();
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("dptr_after_wb1", 32'(dut.r_dptr), 32'd0);
      waitFor(1, 0, "wb0_w0"); step();
      daddr[0*WW +: WW] = 32'h404; dstore[0*WW +: WW] = 32'h11110001;
      waitFor(1, 0, "wb0_w1"); step();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("dptr_after_wb0", 32'(dut.r_dptr), 32'd1);
      waitFor(0, 0, "ifetch_after_wb"); step(); iREN[0] = 1'b0;
      checkOutput("iptr_after_wb", 32'(dut.r_iptr), 32'd1);

      // S->M upgrade by CPU1: invalidate for two cycles, one ack, no RAM
      applyStimulus(1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0);
      pushExp(1, 1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      waitFor(2, 0, "snoop_upg");
      checkOutput("upg_inv_snoop", 32'(ccinv[0]), 32'd1);
      checkOutput("upg_addr0", ccsnoopaddr[0*WW +: WW], 32'h300);
      checkOutput("upg_no_early_ack", 32'(dwait[1]), 32'd1);
      step();
      @(negedge CLK);
      checkOutput("upg_inv_hold", 32'(ccinv[0]), 32'd1);
      step();
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("upg_state", 32'(dut.r_state), 32'(IDLE));
      @(negedge CLK);
      checkOutput("upg_inv_release", 32'(ccinv[0]), 32'd0);
      checkOutput("dptr_after_upg", 32'(dut.r_dptr), 32'd0);

      // Read withdrawn before the RAM answers: no ack, counter cleared
      step();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h700, 32'h0);
      waitFor(3, 0, "wd_ramren");
      dREN[0] = 1'b0;
      step();
      checkOutput("wd_state", 32'(dut.r_state), 32'(IDLE));
      checkOutput("wd_cnt",   32'(dut.r_cnt),   32'd0);
      for (int n = 0; n < 3; n++) begin
         @(negedge CLK);
         checkOutput("wd_no_ack", 32'(dwait[0]), 32'd1);
      end
      step();

      // Reset during a cache-to-cache block after its first word
      applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h600, 32'h0);
      daddr[1*WW +: WW]  = 32'h600;
      dstore[1*WW +: WW] = 32'h33330000;
      pushExp(1, 0, 32'h33330000, 32'h600, 32'h33330000, 1'b1, 1'b0);
      pushExp(1, 1, 32'h0,        32'h600, 32'h33330000, 1'b1, 1'b0);
      waitFor(2, 1, "snoop_rst");
      checkOutput("rdx_inv1", 32'(ccinv[1]), 32'd1);
      dWEN[1] = 1'b1;
      waitFor(1, 0, "rst_c2c_w0"); step();
      RST = 1'b1;
      @(negedge CLK);
      checkOutput("abort_waits",   32'({iwait, dwait}), 32'hF);
      checkOutput("abort_strobes", 32'({ramREN, ramWEN, |ccwait, |ccinv}), 32'h0);
      step();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("abort_state", 32'(dut.r_state), 32'(IDLE));
      checkOutput("abort_cnt",   32'(dut.r_cnt),   32'd0);
      @(negedge CLK);
      checkOutput("abort_dwait_next", 32'(dwait), 32'h3);
      step();
      RST = 1'b0;
      step(); step();

      checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/coherent_bus_ctrl.md
Name: coherent_bus_ctrl

Overview:
- Parametrised N-CPU memory/coherence bus controller.
- Sits between the per-CPU cache pairs (icache/dcache) and the single-port RAM.
- Round-robin arbitrates data and instruction requests and broadcasts snoops (invalidate or writeback) for MSI coherence.
- Serves misses either cache-to-cache (writing the block back to RAM at the same time) or from RAM.

Parameters:
- CPUS, 2, number of cache pairs; any value from 1 to 8.
- BLOCK_WORDS, 2, words per data-cache block; each word is its own handshake.
- WORD_W, 32, data/address width (word_t).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- iREN  in  CPUS  instruction read request per CPU
- iaddr  in  CPUS*WORD_W  instruction address per CPU
- iwait  out  CPUS  low for one cycle when iload is valid
- iload  out  CPUS*WORD_W  instruction data
- dREN, dWEN  in  CPUS each  data read / write (writeback) request
- daddr, dstore  in  CPUS*WORD_W each  data address / store data
- dwait  out  CPUS  low for one cycle on word completion or upgrade ack
- dload  out  CPUS*WORD_W  data load
- ccwrite  in  CPUS  requester intends M (BusRdX/upgrade)
- cctrans  in  CPUS  requester cache line changing state
- ccwait  out  CPUS  snooped cache must stall its CPU
- ccinv  out  CPUS  snooped cache must invalidate the snooped address
- ccsnoopaddr  out  CPUS*WORD_W  address under snoop
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- ramREN, ramWEN  out  1 each  RAM strobes
- ramaddr, ramstore  out  WORD_W each  RAM address / write data

Behaviour:
- Reset: state IDLE; data and instruction round-robin pointers 0; word counter 0; all iwait and dwait 1; ccwait, ccinv, ramREN, ramWEN 0; all address and data outputs 0. Reset in any state aborts the transfer the same cycle.
- Outputs are combinational from the registered state, grant index r (requester) and snooper index s.
- Priority in IDLE, in this order:
  1. Any dWEN without cctrans → WB.
  2. Any cctrans → SNOOP.
  3. Any dREN → RAM_RD.
  4. Any iREN → IFETCH.
- Data grants use one round-robin search starting at dptr. Instruction grants use a separate search from iptr.
- A pointer advances to grant+1 mod CPUS when its transaction ends. This holds in every state that returns to IDLE.
- SNOOP (1 cycle):
  - For every j≠r: ccwait[j]=1, ccsnoopaddr[j]=daddr[r], ccinv[j]=ccwrite[r].
  - Next state by priority:
    - Some j≠r has dWEN=1 (M copy, lowest index from r+1 wins) → s=j, C2C.
    - dREN[r]=0 (S→M upgrade) → UPGRADE.
    - Otherwise → RAM_RD.
- UPGRADE (1 cycle): ccinv/ccwait held as in SNOOP; dwait[r]=0; → IDLE.
- C2C:
  - Drive ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s], dload[r]=dstore[s]. ccwait[s] stays 1.
  - On ramstate==ACCESS: dwait[r]=dwait[s]=0 in the same cycle; counter++.
- RAM_RD: ramREN=1, ramaddr=daddr[r], dload[r]=ramload; on ACCESS dwait[r]=0, counter++.
- WB: ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r]; on ACCESS dwait[r]=0, counter++.
- Block end: when the counter reaches BLOCK_WORDS-1 and ACCESS is seen, the counter wraps to 0 and the state goes to IDLE.
- IFETCH: ramREN=1, ramaddr=iaddr[k], iload[k]=ramload; on ACCESS iwait[k]=0 → IDLE. A single word only; a data request arriving mid-fetch waits until the fetch ends.
- ramstate BUSY, FREE or ERROR means not ready: hold all outputs.
- Withdrawn request: if the granted requester (or snooper in C2C) drops its request before ACCESS, return to IDLE next cycle with no ack and clear the counter.
- Never drive ramREN and ramWEN together.
- Requesters not granted see wait=1 and ccwait=0 unless they are being snooped.

Decomposition:
- cpu_types_pkg: word_t, ramstate_t.
- New package typedef: busstate_t {IDLE, SNOOP, UPGRADE, C2C, RAM_RD, WB, IFETCH}.
- Sub-module rr_arbiter: parameter N; inputs req[N], ptr; outputs grant index and valid. Instantiated twice, once for data and once for instructions.

Test Plan:
- Reset then CPUS=2, iREN[0]=iREN[1]=1 with RAM ACCESS after 2 cycles → iwait[0] low first, then iwait[1]; iptr alternates 0→1→0.
- CPU0 dREN+cctrans, ccwrite=0, addr 0x100; CPU1 idle → SNOOP shows ccwait[1]=1, ccsnoopaddr[1]=0x100, ccinv[1]=0; then RAM_RD delivers 2 words with dwait[0] pulses.
- CPU0 read-miss on 0x200 while CPU1 asserts dWEN with dstore 0xDEADBEEF/0xCAFEF00D → ramWEN=1 and dload[0] equal to each word; dwait[0] and dwait[1] pulse together twice.
- CPU1 upgrade (cctrans=1, ccwrite=1, dREN=0) on 0x300 → ccinv[0]=1 for 2 cycles, single dwait[1] pulse, back to IDLE.
- Simultaneous dWEN[0]=dWEN[1]=1 with dptr=1 → CPU1 served first, then CPU0; concurrent iREN stalls until both writebacks finish.
- RST asserted mid-C2C after word 0 → next cycle all waits 1, strobes 0, state IDLE, counter 0.
